// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line. Hits return
// the word one cycle after the request. Misses issue a single word fetch to
// the memory controller and then fill the line. A flush that arrives during a
// fetch lets the fill finish but suppresses the response.
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_valid,
   input  logic [31:0] if_addr,
   input  logic        if_clear,
   output logic        if_ready,
   output logic [31:0] if_inst,
   output logic        mc_valid,
   output logic [31:0] mc_addr,
   input  logic        mc_done,
   input  logic [31:0] mc_inst
);

   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic {
      IDLE,
      FETCH
   } state_e;

   state_e                state_q, state_d;
   logic [31:0]           req_addr_q, req_addr_d;
   logic                  drop_q, drop_d;
   logic                  if_ready_q, if_ready_d;
   logic [31:0]           if_inst_q, if_inst_d;

   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [31:0]           data_q [LINES];

   logic [INDEX_BITS-1:0] lk_index, fill_index;
   logic [TAG_BITS-1:0]   lk_tag, fill_tag;
   logic                  lk_hit;
   logic                  accept;
   logic                  fill_we;

   // Lookup uses the incoming PC; the fill uses the latched request address.
   assign lk_index   = if_addr[INDEX_BITS+1:2];
   assign lk_tag     = if_addr[31:INDEX_BITS+2];
   assign fill_index = req_addr_q[INDEX_BITS+1:2];
   assign fill_tag   = req_addr_q[31:INDEX_BITS+2];
   assign lk_hit     = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
   assign accept     = (state_q == IDLE) && if_valid && !if_clear;
   // A completion pulse seen outside FETCH is a protocol error and is ignored.
   assign fill_we    = (state_q == FETCH) && mc_done && rdy;

   // State register: synchronous reset, frozen while rdy is low.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      if (rst) begin
         state_q <= IDLE;
      end else if (rdy) begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a missed lookup starts a fetch, completion ends it.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && !lk_hit) state_d = FETCH;
         FETCH:   if (mc_done)           state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs. mc_valid is deliberately combinational on mc_done so the
   // controller never sees a live request during its own completion pulse.
   always_comb begin
      mc_valid = (state_q == FETCH) && !mc_done;
      mc_addr  = req_addr_q;
      if_ready = if_ready_q && rdy;
      if_inst  = if_inst_q;
   end

   // Datapath next values: response pulse, returned word, request latch, drop.
   always_comb begin
      req_addr_d = req_addr_q;
      drop_d     = drop_q;
      if_ready_d = 1'b0;
      if_inst_d  = if_inst_q;
      if (accept) begin
         if (lk_hit) begin
            if_ready_d = 1'b1;
            if_inst_d  = data_q[lk_index];
         end else begin
            // Masking rather than slicing keeps the word-aligned address in one step.
            req_addr_d = if_addr & ~32'h3;
         end
      end
      if (state_q == FETCH) begin
         if (mc_done) begin
            drop_d = 1'b0;
            if (!(drop_q || if_clear)) begin
               if_ready_d = 1'b1;
               if_inst_d  = mc_inst;
            end
         end else if (if_clear) begin
            drop_d = 1'b1;
         end
      end
   end

   // Datapath registers with reset values, held while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr_q <= 32'h0;
         drop_q     <= 1'b0;
         if_ready_q <= 1'b0;
         if_inst_q  <= 32'h0;
      end else if (rdy) begin
         req_addr_q <= req_addr_d;
         drop_q     <= drop_d;
         if_ready_q <= if_ready_d;
         if_inst_q  <= if_inst_d;
      end
   end

   // Valid bits: cleared only by reset, set by a fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (fill_we) begin
         valid_q[fill_index] <= 1'b1;
      end
   end

   // Tag and data arrays: written on fill, never reset.
   always_ff @(posedge clk) begin
      // NOTE: tag and data storage has no reset; the valid bits alone make
      // stale contents unreachable, and that lets the arrays map onto RAM.
      if (fill_we) begin
         tag_q[fill_index]  <= fill_tag;
         data_q[fill_index] <= mc_inst;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache. Inputs are driven 1 ns after the
// rising edge and outputs are sampled in that same window, so one "tick"
// equals one clock cycle and comparisons never race the edge.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        if_valid;
   logic [31:0] if_addr;
   logic        if_clear;
   logic        if_ready;
   logic [31:0] if_inst;
   logic        mc_valid;
   logic [31:0] mc_addr;
   logic        mc_done;
   logic [31:0] mc_inst;

   int tests_run    = 0;
   int tests_failed = 0;

   icache #(.INDEX_BITS(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .if_valid (if_valid),
      .if_addr  (if_addr),
      .if_clear (if_clear),
      .if_ready (if_ready),
      .if_inst  (if_inst),
      .mc_valid (mc_valid),
      .mc_addr  (mc_addr),
      .mc_done  (mc_done),
      .mc_inst  (mc_inst)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a miss on addr and complete it after gap cycles in FETCH. Returns
   // in the cycle after mc_done, where the response pulse is expected.
   task automatic do_miss(input logic [31:0] addr, input logic [31:0] word, input int gap);
      if_valid = 1'b1;
      if_addr  = addr;
      tick();
      if_valid = 1'b0;
      repeat (gap) tick();
      mc_done = 1'b1;
      mc_inst = word;
      tick();
      mc_done = 1'b0;
      mc_inst = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; if_valid = 1'b0; if_addr = 32'h0;
      if_clear = 1'b0; mc_done = 1'b0; mc_inst = 32'h0;
      tick(); tick();
      rst = 1'b0;
      tests_run++;
      if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_if_ready: got %b want 0", if_ready); end
      tests_run++;
      if (if_inst !== 32'h0) begin tests_failed++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
      tests_run++;
      if (mc_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mc_valid: got %b want 0", mc_valid); end
      tests_run++;
      if (mc_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mc_addr: got %h want 0", mc_addr); end
   endtask

   task automatic test_cold_miss();
      if_valid = 1'b1; if_addr = 32'h0;
      tick();
      if_valid = 1'b0;
      tests_run++;
      if (mc_valid !== 1'b1) begin tests_failed++; $display("FAIL cold_mc_valid: got %b want 1", mc_valid); end
      tests_run++;
      if (mc_addr !== 32'h0) begin tests_failed++; $display("FAIL cold_mc_addr: got %h want 0", mc_addr); end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (mc_valid !== 1'b1 || if_ready !== 1'b0) begin
            tests_failed++; $display("FAIL cold_wait%0d: mc_valid=%b if_ready=%b want 1/0", i, mc_valid, if_ready);
         end
      end
      mc_done = 1'b1; mc_inst = 32'h0000_0093;
      #1;
      tests_run++;
      if (mc_valid !== 1'b0) begin tests_failed++; $display("FAIL cold_mc_valid_on_done: got %b want 0", mc_valid); end
      tick();
      mc_done = 1'b0; mc_inst = 32'h0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0000_0093) begin
         tests_failed++; $display("FAIL cold_resp: ready=%b inst=%h want 1/00000093", if_ready, if_inst);
      end
      tests_run++;
      if (mc_valid !== 1'b0) begin tests_failed++; $display("FAIL cold_mc_valid_after: got %b want 0", mc_valid); end
      tick();
      tests_run++;
      if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL cold_pulse_width: got %b want 0", if_ready); end
   endtask

   task automatic test_hit();
      if_valid = 1'b1; if_addr = 32'h0000_0002;
      tick();
      if_valid = 1'b0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0000_0093) begin
         tests_failed++; $display("FAIL hit_resp: ready=%b inst=%h want 1/00000093", if_ready, if_inst);
      end
      tests_run++;
      if (mc_valid !== 1'b0) begin tests_failed++; $display("FAIL hit_mc_valid: got %b want 0", mc_valid); end
      tick();
      tests_run++;
      if (if_ready !== 1'b0 || mc_valid !== 1'b0) begin
         tests_failed++; $display("FAIL hit_after: ready=%b mc_valid=%b want 0/0", if_ready, mc_valid);
      end
   endtask

   task automatic test_conflict();
      if_valid = 1'b1; if_addr = 32'h0000_0100;
      tick();
      if_valid = 1'b0;
      tests_run++;
      if (mc_valid !== 1'b1 || mc_addr !== 32'h0000_0100) begin
         tests_failed++; $display("FAIL conflict_req: mc_valid=%b addr=%h want 1/00000100", mc_valid, mc_addr);
      end
      tick();
      mc_done = 1'b1; mc_inst = 32'h0010_0113;
      tick();
      mc_done = 1'b0; mc_inst = 32'h0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0010_0113) begin
         tests_failed++; $display("FAIL conflict_resp: ready=%b inst=%h want 1/00100113", if_ready, if_inst);
      end
      tick();
      // Line 0 now holds tag of 0x100, so 0x0 must miss again.
      if_valid = 1'b1; if_addr = 32'h0;
      tick();
      if_valid = 1'b0;
      tests_run++;
      if (mc_valid !== 1'b1 || mc_addr !== 32'h0 || if_ready !== 1'b0) begin
         tests_failed++; $display("FAIL conflict_remiss: mc_valid=%b addr=%h ready=%b want 1/0/0", mc_valid, mc_addr, if_ready);
      end
      mc_done = 1'b1; mc_inst = 32'h0000_0093;
      tick();
      mc_done = 1'b0; mc_inst = 32'h0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0000_0093) begin
         tests_failed++; $display("FAIL conflict_refill: ready=%b inst=%h want 1/00000093", if_ready, if_inst);
      end
      tick();
   endtask

   task automatic test_flush();
      if_valid = 1'b1; if_addr = 32'h0000_0008;
      tick();
      if_valid = 1'b0;
      tick();
      if_clear = 1'b1;
      tick();
      if_clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (mc_valid !== 1'b1 || mc_addr !== 32'h0000_0008 || if_ready !== 1'b0) begin
            tests_failed++; $display("FAIL flush_hold%0d: mc_valid=%b addr=%h ready=%b want 1/00000008/0", i, mc_valid, mc_addr, if_ready);
         end
         tick();
      end
      mc_done = 1'b1; mc_inst = 32'h0000_0213;
      tick();
      mc_done = 1'b0; mc_inst = 32'h0;
      tests_run++;
      if (if_ready !== 1'b0 || mc_valid !== 1'b0) begin
         tests_failed++; $display("FAIL flush_no_resp: ready=%b mc_valid=%b want 0/0", if_ready, mc_valid);
      end
      tick();
      tests_run++;
      if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_no_resp_late: got %b want 0", if_ready); end
      if_valid = 1'b1; if_addr = 32'h0000_0008;
      tick();
      if_valid = 1'b0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0000_0213 || mc_valid !== 1'b0) begin
         tests_failed++; $display("FAIL flush_refetch: ready=%b inst=%h mc_valid=%b want 1/00000213/0", if_ready, if_inst, mc_valid);
      end
      tick();
   endtask

   task automatic test_clear_with_done();
      if_valid = 1'b1; if_addr = 32'h0000_000C;
      tick();
      if_valid = 1'b0;
      mc_done = 1'b1; mc_inst = 32'h0000_0313; if_clear = 1'b1;
      tick();
      mc_done = 1'b0; mc_inst = 32'h0; if_clear = 1'b0;
      tests_run++;
      if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL clrdone_no_resp: got %b want 0", if_ready); end
      if_valid = 1'b1; if_addr = 32'h0000_000C;
      tick();
      if_valid = 1'b0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0000_0313) begin
         tests_failed++; $display("FAIL clrdone_refetch: ready=%b inst=%h want 1/00000313", if_ready, if_inst);
      end
      tick();
   endtask

   task automatic test_stall();
      if_valid = 1'b1; if_addr = 32'h0000_0010;
      tick();
      if_valid = 1'b0;
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (mc_valid !== 1'b1 || mc_addr !== 32'h0000_0010 || if_ready !== 1'b0) begin
            tests_failed++; $display("FAIL stall_hold%0d: mc_valid=%b addr=%h ready=%b want 1/00000010/0", i, mc_valid, mc_addr, if_ready);
         end
      end
      rdy = 1'b1;
      tick();
      mc_done = 1'b1; mc_inst = 32'h0000_0413;
      tick();
      mc_done = 1'b0; mc_inst = 32'h0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0000_0413) begin
         tests_failed++; $display("FAIL stall_resp: ready=%b inst=%h want 1/00000413", if_ready, if_inst);
      end
      tick();
      tests_run++;
      if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_single_pulse: got %b want 0", if_ready); end
   endtask

   task automatic test_idle_done();
      mc_done = 1'b1; mc_inst = 32'hDEAD_BEEF;
      tick();
      mc_done = 1'b0; mc_inst = 32'h0;
      tests_run++;
      if (if_ready !== 1'b0 || mc_valid !== 1'b0) begin
         tests_failed++; $display("FAIL idle_done: ready=%b mc_valid=%b want 0/0", if_ready, mc_valid);
      end
      if_valid = 1'b1; if_addr = 32'h0000_0010;
      tick();
      if_valid = 1'b0;
      tests_run++;
      if (if_ready !== 1'b1 || if_inst !== 32'h0000_0413) begin
         tests_failed++; $display("FAIL idle_done_intact: ready=%b inst=%h want 1/00000413", if_ready, if_inst);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_words [3];
      exp_words[0] = 32'h0000_0093;
      exp_words[1] = 32'h0000_0513;
      exp_words[2] = 32'h0000_0213;
      do_miss(32'h0000_0004, 32'h0000_0513, 1);
      tick();
      if_valid = 1'b1; if_addr = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) if_addr = 32'(4 * (i + 1));
         else       if_valid = 1'b0;
         tests_run++;
         if (if_ready !== 1'b1 || if_inst !== exp_words[i] || mc_valid !== 1'b0) begin
            tests_failed++; $display("FAIL stream%0d: ready=%b inst=%h mc_valid=%b want 1/%h/0", i, if_ready, if_inst, mc_valid, exp_words[i]);
         end
      end
      tick();
      tests_run++;
      if (if_ready !== 1'b0) begin tests_failed++; $display("FAIL stream_end: got %b want 0", if_ready); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_flush();
      test_clear_with_done();
      test_stall();
      test_idle_done();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
